// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and types for the UART boot loader.
// Optional read-back support is enabled with BOOT_READBACK_EN.
package uart_boot_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned LEN_W  = 9;

    localparam logic [31:0] DEF_TIMEOUT_CYCLES = 32'd5_000_000;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_GO    = 8'h47;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_DATA,
        ST_CKSUM,
        ST_RESP,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_CAP,
        ST_RD_SEND
    } state_t;

    typedef enum logic [1:0] {
        OP_WRITE,
        OP_GO,
        OP_READ
    } op_t;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Byte link (UART rx/tx) and memory port of the boot loader.
// BOOT_READBACK_EN adds the memory read strobe and read data.
interface uart_boot_loader_if;
    import uart_boot_loader_pkg::*;

    logic              rx_rdy;
    logic [BYTE_W-1:0] rx_data;
    logic              tx_busy;
    logic              tx_ld;
    logic [BYTE_W-1:0] tx_data;
    logic              mem_we;
    logic [WORD_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_din;
`ifdef BOOT_READBACK_EN
    logic              mem_re;
    logic [WORD_W-1:0] mem_dout;
`endif

    modport master (
        input  rx_rdy, rx_data, tx_busy,
`ifdef BOOT_READBACK_EN
        output mem_re,
        input  mem_dout,
`endif
        output tx_ld, tx_data, mem_we, mem_addr, mem_din
    );

    modport slave (
        output rx_rdy, rx_data, tx_busy,
`ifdef BOOT_READBACK_EN
        input  mem_re,
        output mem_dout,
`endif
        input  tx_ld, tx_data, mem_we, mem_addr, mem_din
    );

endinterface

// File: rtl/uart_boot_loader_timeout.sv
// Inter-byte timeout: loadable down-counter, expired flags after TIMEOUT_CYCLES enabled cycles.
module boot_timeout
    import uart_boot_loader_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [31:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count   <= TIMEOUT_CYCLES;
            expired <= 1'b0;
        end else if (en && !expired) begin
            if (count <= 32'd1) begin
                expired <= 1'b1;
            end else begin
                count <= count - 32'd1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Host download responder: parses W/G frames, writes memory words, replies ACK/NAK, releases CPU.
// Define BOOT_READBACK_EN to add the R (memory read-back) frame.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [31:0] RESET_PC       = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    uart_boot_loader_if.master  bus,
    output logic                cpu_hold,
    output logic [WORD_W-1:0]   boot_pc
);

    state_t            state, state_d;
    op_t               op, op_d;
    logic [1:0]        idx, idx_d;
    logic [WORD_W-1:0] addr, addr_d;
    logic [LEN_W-1:0]  cnt, cnt_d;
    logic [BYTE_W-1:0] csum, csum_d;
    logic [BYTE_W-1:0] resp, resp_d;
    logic              go, go_d;
    logic              rel, rel_d;
    logic              tx_ld_q, tx_ld_d;
    logic [BYTE_W-1:0] tx_data_q, tx_data_d;
    logic              mem_we_q, mem_we_d;
    logic [WORD_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_din_q, mem_din_d;
    logic              hold_q, hold_d;
    logic [WORD_W-1:0] pc_q, pc_d;
`ifdef BOOT_READBACK_EN
    logic              mem_re_q, mem_re_d;
    logic [WORD_W-1:0] rd_word, rd_word_d;
`endif

    logic timing_c;
    logic expired;

    assign timing_c = (state == ST_ADDR) || (state == ST_LEN) ||
                      (state == ST_DATA) || (state == ST_CKSUM);

    boot_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.rx_rdy || !timing_c),
        .en      (timing_c),
        .expired (expired)
    );

    // Frame parser, word assembler and response sequencer
    always_comb begin
        state_d    = state;
        op_d       = op;
        idx_d      = idx;
        addr_d     = addr;
        cnt_d      = cnt;
        csum_d     = csum;
        resp_d     = resp;
        go_d       = go;
        rel_d      = 1'b0;
        tx_ld_d    = 1'b0;
        tx_data_d  = tx_data_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        hold_d     = rel ? 1'b0 : hold_q;
        pc_d       = pc_q;
`ifdef BOOT_READBACK_EN
        mem_re_d   = 1'b0;
        rd_word_d  = rd_word;
`endif
        if (timing_c && expired) begin
            state_d = ST_RESP;
            resp_d  = NAK_BYTE;
            go_d    = 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (bus.rx_rdy) begin
                    csum_d = '0;
                    idx_d  = '0;
                    go_d   = 1'b0;
                    case (bus.rx_data)
                        CMD_WRITE: begin op_d = OP_WRITE; state_d = ST_ADDR; end
                        CMD_GO:    begin op_d = OP_GO;    state_d = ST_ADDR; end
`ifdef BOOT_READBACK_EN
                        CMD_READ:  begin op_d = OP_READ;  state_d = ST_ADDR; end
`endif
                        default: ;
                    endcase
                end
                ST_ADDR: if (bus.rx_rdy) begin
                    csum_d = csum + bus.rx_data;
                    idx_d  = idx + 2'd1;
                    if (idx == 2'd3) begin
                        addr_d  = {addr[23:0], bus.rx_data[7:2], 2'b00};
                        state_d = (op == OP_GO) ? ST_CKSUM : ST_LEN;
                    end else begin
                        addr_d = {addr[23:0], bus.rx_data};
                    end
                end
                ST_LEN: if (bus.rx_rdy) begin
                    csum_d  = csum + bus.rx_data;
                    cnt_d   = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                    idx_d   = '0;
                    state_d = (op == OP_WRITE) ? ST_DATA : ST_CKSUM;
                end
                ST_DATA: if (bus.rx_rdy) begin
                    csum_d    = csum + bus.rx_data;
                    mem_din_d = {mem_din_q[23:0], bus.rx_data};
                    idx_d     = idx + 2'd1;
                    if (idx == 2'd3) begin
                        mem_we_d   = 1'b1;
                        mem_addr_d = addr;
                        addr_d     = addr + 32'd4;
                        cnt_d      = cnt - 9'd1;
                        if (cnt == 9'd1) state_d = ST_CKSUM;
                    end
                end
                ST_CKSUM: if (bus.rx_rdy) begin
                    state_d = ST_RESP;
                    if (bus.rx_data == csum) begin
                        resp_d = ACK_BYTE;
                        go_d   = (op == OP_GO);
`ifdef BOOT_READBACK_EN
                        if (op == OP_READ) state_d = ST_RD_REQ;
`endif
                    end else begin
                        resp_d = NAK_BYTE;
                        go_d   = 1'b0;
                    end
                end
                // A GO re-raises cpu_hold for one cycle while boot_pc updates
                ST_RESP: if (!bus.tx_busy) begin
                    tx_ld_d   = 1'b1;
                    tx_data_d = resp;
                    state_d   = ST_IDLE;
                    if (go) begin
                        pc_d   = addr;
                        hold_d = 1'b1;
                        rel_d  = 1'b1;
                    end
                end
`ifdef BOOT_READBACK_EN
                ST_RD_REQ: begin
                    mem_re_d   = 1'b1;
                    mem_addr_d = addr;
                    state_d    = ST_RD_WAIT;
                end
                ST_RD_WAIT: state_d = ST_RD_CAP;
                ST_RD_CAP: begin
                    rd_word_d = bus.mem_dout;
                    idx_d     = '0;
                    state_d   = ST_RD_SEND;
                end
                ST_RD_SEND: if (!bus.tx_busy) begin
                    tx_ld_d   = 1'b1;
                    tx_data_d = rd_word[31:24];
                    rd_word_d = {rd_word[23:0], 8'h00};
                    idx_d     = idx + 2'd1;
                    if (idx == 2'd3) begin
                        addr_d  = addr + 32'd4;
                        cnt_d   = cnt - 9'd1;
                        state_d = (cnt == 9'd1) ? ST_RESP : ST_RD_REQ;
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op         <= OP_WRITE;
            idx        <= '0;
            addr       <= '0;
            cnt        <= '0;
            csum       <= '0;
            resp       <= '0;
            go         <= 1'b0;
            rel        <= 1'b0;
            tx_ld_q    <= 1'b0;
            tx_data_q  <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            hold_q     <= 1'b1;
            pc_q       <= RESET_PC;
`ifdef BOOT_READBACK_EN
            mem_re_q   <= 1'b0;
            rd_word    <= '0;
`endif
        end else begin
            state      <= state_d;
            op         <= op_d;
            idx        <= idx_d;
            addr       <= addr_d;
            cnt        <= cnt_d;
            csum       <= csum_d;
            resp       <= resp_d;
            go         <= go_d;
            rel        <= rel_d;
            tx_ld_q    <= tx_ld_d;
            tx_data_q  <= tx_data_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            hold_q     <= hold_d;
            pc_q       <= pc_d;
`ifdef BOOT_READBACK_EN
            mem_re_q   <= mem_re_d;
            rd_word    <= rd_word_d;
`endif
        end
    end

    assign bus.tx_ld    = tx_ld_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_din  = mem_din_q;
`ifdef BOOT_READBACK_EN
    assign bus.mem_re   = mem_re_q;
`endif
    assign cpu_hold     = hold_q;
    assign boot_pc      = pc_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: table of frames plus busy/GO/timeout/reset sequences.
module tb_uart_boot_loader;
    import uart_boot_loader_pkg::*;

    localparam logic [31:0] TMO    = 32'd200;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_hold;
    logic [31:0] boot_pc;

    uart_boot_loader_if bif();

    uart_boot_loader #(.TIMEOUT_CYCLES(TMO), .RESET_PC(RST_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bif.master),
        .cpu_hold (cpu_hold),
        .boot_pc  (boot_pc)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int ld_cyc = 0;
    int last_rx_cyc = 0;
    logic [63:0] wr_q[$];
    logic [7:0]  tx_q[$];
    logic [31:0] pc_at_ld = '0;
    logic        hold_at_ld = 1'b0;
    logic        hold_after = 1'b0;
    logic        prev_ld = 1'b0;

    always @(posedge clk) cyc++;

    // Observe DUT outputs mid-cycle
    always @(negedge clk) begin
        if (prev_ld) hold_after = cpu_hold;
        prev_ld = bif.tx_ld;
        if (bif.rx_rdy) last_rx_cyc = cyc;
        if (bif.mem_we) wr_q.push_back({bif.mem_addr, bif.mem_din});
        if (bif.tx_ld) begin
            tx_q.push_back(bif.tx_data);
            ld_cyc     = cyc;
            pc_at_ld   = boot_pc;
            hold_at_ld = cpu_hold;
        end
    end

`ifdef BOOT_READBACK_EN
    logic [31:0] mem_model [logic [31:0]];
    always @(negedge clk) if (bif.mem_we) mem_model[bif.mem_addr] = bif.mem_din;
    always @(posedge clk)
        if (bif.mem_re) bif.mem_dout <= mem_model.exists(bif.mem_addr) ? mem_model[bif.mem_addr] : 32'h0;
`endif

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bif.rx_rdy  = 1'b1;
        bif.rx_data = b;
        step(1);
        bif.rx_rdy  = 1'b0;
        step(2);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] addr, input logic [7:0] n,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [7:0] ck_err);
        logic [7:0]  ck;
        logic [7:0]  b;
        logic [31:0] w;
        ck = 8'h00;
        send_byte(cmd);
        for (int i = 0; i < 4; i++) begin
            b = addr[31-8*i -: 8];
            ck = ck + b;
            send_byte(b);
        end
        if (cmd != CMD_GO) begin
            ck = ck + n;
            send_byte(n);
        end
        if (cmd == CMD_WRITE) begin
            for (int k = 0; k < int'(n); k++) begin
                w = (k == 0) ? d0 : d1;
                for (int j = 0; j < 4; j++) begin
                    b = w[31-8*j -: 8];
                    ck = ck + b;
                    send_byte(b);
                end
            end
        end
        send_byte(ck + ck_err);
    endtask

    task automatic wait_tx(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && tx_q.size() < n; i++) step(1);
        ok = (tx_q.size() >= n);
        step(3);
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [31:0] addr;
        logic [7:0]  n;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [7:0]  ck_err;
        logic [7:0]  reply;
        logic [31:0] wa0;
        logic [31:0] wa1;
    } vec_t;

    vec_t vecs[5];
    bit   ok;

    initial begin
        vecs[0] = '{"w_good",    CMD_WRITE, 32'h0000_0100, 8'd2, 32'h1122_3344, 32'h5566_7788, 8'h00, 8'h06, 32'h0000_0100, 32'h0000_0104};
        vecs[1] = '{"w_badck",   CMD_WRITE, 32'h0000_0100, 8'd2, 32'h1122_3344, 32'h5566_7788, 8'h01, 8'h15, 32'h0000_0100, 32'h0000_0104};
        vecs[2] = '{"w_wrap",    CMD_WRITE, 32'hFFFF_FFFC, 8'd2, 32'hA1B2_C3D4, 32'h0BAD_F00D, 8'h00, 8'h06, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[3] = '{"w_unalign", CMD_WRITE, 32'h0000_0203, 8'd1, 32'hDEAD_BEEF, 32'h0,         8'h00, 8'h06, 32'h0000_0200, 32'h0};
        vecs[4] = '{"g_badck",   CMD_GO,    32'h0000_0040, 8'd0, 32'h0,         32'h0,         8'h80, 8'h15, 32'h0,         32'h0};

        rst = 1'b1;
        bif.rx_rdy  = 1'b0;
        bif.rx_data = 8'h00;
        bif.tx_busy = 1'b0;
        step(3);
        check("rst_tx_ld",    64'(bif.tx_ld),    64'h0);
        check("rst_tx_data",  64'(bif.tx_data),  64'h0);
        check("rst_mem_we",   64'(bif.mem_we),   64'h0);
        check("rst_mem_addr", 64'(bif.mem_addr), 64'h0);
        check("rst_mem_din",  64'(bif.mem_din),  64'h0);
        check("rst_cpu_hold", 64'(cpu_hold),     64'h1);
        check("rst_boot_pc",  64'(boot_pc),      64'(RST_PC));
        rst = 1'b0;
        step(2);

        for (int v = 0; v < 5; v++) begin
            wr_q.delete();
            tx_q.delete();
            send_frame(vecs[v].cmd, vecs[v].addr, vecs[v].n, vecs[v].d0, vecs[v].d1, vecs[v].ck_err);
            wait_tx(1, 200, ok);
            check({vecs[v].name, "_seen"},  64'(ok), 64'h1);
            check({vecs[v].name, "_count"}, 64'(tx_q.size()), 64'h1);
            if (tx_q.size() > 0) check({vecs[v].name, "_reply"}, 64'(tx_q[0]), 64'(vecs[v].reply));
            check({vecs[v].name, "_latency"}, 64'(ld_cyc - last_rx_cyc >= 2), 64'h1);
            check({vecs[v].name, "_nwr"}, 64'(wr_q.size()), (vecs[v].cmd == CMD_WRITE) ? 64'(vecs[v].n) : 64'h0);
            if (wr_q.size() > 0) check({vecs[v].name, "_wr0"}, wr_q[0], {vecs[v].wa0, vecs[v].d0});
            if (wr_q.size() > 1) check({vecs[v].name, "_wr1"}, wr_q[1], {vecs[v].wa1, vecs[v].d1});
            check({vecs[v].name, "_hold"}, 64'(cpu_hold), 64'h1);
            check({vecs[v].name, "_pc"},   64'(boot_pc),  64'(RST_PC));
        end

        // Unknown bytes in IDLE are ignored
        tx_q.delete();
        send_byte(8'h33);
        send_byte(8'h00);
        send_byte(8'hFF);
        step(30);
        check("unknown_silent", 64'(tx_q.size()), 64'h0);

        // GO held off by a busy transmitter
        tx_q.delete();
        bif.tx_busy = 1'b1;
        send_frame(CMD_GO, 32'h0000_0040, 8'd0, 32'h0, 32'h0, 8'h00);
        step(20);
        check("busy_no_ld", 64'(tx_q.size()), 64'h0);
        check("busy_hold",  64'(cpu_hold),    64'h1);
        bif.tx_busy = 1'b0;
        wait_tx(1, 50, ok);
        check("go_seen",       64'(ok), 64'h1);
        check("go_count",      64'(tx_q.size()), 64'h1);
        if (tx_q.size() > 0) check("go_reply", 64'(tx_q[0]), 64'h06);
        check("go_pc_at_ld",   64'(pc_at_ld),   64'h40);
        check("go_hold_at_ld", 64'(hold_at_ld), 64'h1);
        check("go_hold_after", 64'(hold_after), 64'h0);
        check("go_pc",         64'(boot_pc),    64'h40);
        check("go_hold",       64'(cpu_hold),   64'h0);

        // Second GO re-pulses hold then releases at the new PC
        tx_q.delete();
        send_frame(CMD_GO, 32'h0000_0080, 8'd0, 32'h0, 32'h0, 8'h00);
        wait_tx(1, 50, ok);
        if (tx_q.size() > 0) check("go2_reply", 64'(tx_q[0]), 64'h06);
        check("go2_pc_at_ld",   64'(pc_at_ld),   64'h80);
        check("go2_hold_at_ld", 64'(hold_at_ld), 64'h1);
        check("go2_hold_after", 64'(hold_after), 64'h0);
        check("go2_hold",       64'(cpu_hold),   64'h0);

        // Stalled frame times out with NAK, next frame still works
        tx_q.delete();
        wr_q.delete();
        send_byte(CMD_WRITE);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_tx(1, int'(TMO) + 100, ok);
        check("tmo_seen", 64'(ok), 64'h1);
        if (tx_q.size() > 0) check("tmo_reply", 64'(tx_q[0]), 64'h15);
        tx_q.delete();
        send_frame(CMD_WRITE, 32'h0000_0300, 8'd1, 32'hCAFE_BABE, 32'h0, 8'h00);
        wait_tx(1, 200, ok);
        if (tx_q.size() > 0) check("post_tmo_reply", 64'(tx_q[0]), 64'h06);
        if (wr_q.size() > 0) check("post_tmo_wr", wr_q[0], {32'h0000_0300, 32'hCAFE_BABE});
        check("post_tmo_nwr", 64'(wr_q.size()), 64'h1);

        // Reset in the middle of DATA discards the frame
        tx_q.delete();
        wr_q.delete();
        send_byte(CMD_WRITE);
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFC);
        send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(40);
        check("rstmid_no_tx", 64'(tx_q.size()), 64'h0);
        check("rstmid_no_wr", 64'(wr_q.size()), 64'h0);
        check("rstmid_hold",  64'(cpu_hold),    64'h1);
        check("rstmid_pc",    64'(boot_pc),     64'(RST_PC));

`ifdef BOOT_READBACK_EN
        tx_q.delete();
        send_frame(CMD_READ, 32'h0000_0100, 8'd1, 32'h0, 32'h0, 8'h00);
        wait_tx(5, 200, ok);
        check("rd_count", 64'(tx_q.size()), 64'h5);
        if (tx_q.size() == 5)
            check("rd_bytes", {24'h0, tx_q[0], tx_q[1], tx_q[2], tx_q[3], tx_q[4]}, 64'h11_2233_4406);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
